bin2bcd_seq: RTL and testbench

//  Sequential, parametrised binary-to-BCD converter (shift-add-3 / double-dabble).

---
 rtl/bin2bcd_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 132 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_if.sv
// Start/busy/done handshake and result bus for the sequential binary-to-BCD converter.
// The neg signal exists only when BIN2BCD_SIGNED_EN is defined.
interface bin2bcd_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
`ifdef BIN2BCD_SIGNED_EN
  logic                  neg;

  modport master (output start, bin, input busy, done, bcd, ovf, neg);
  modport slave  (input start, bin, output busy, done, bcd, ovf, neg);
`else
  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Optional feature macro: BIN2BCD_SIGNED_EN (two's-complement operand, neg output).
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic      clk,
  input  logic      reset,
  bin2bcd_if.slave  bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [BCD_W-1:0]   corr;
  logic [BIN_W-1:0]   mag;
  logic               carry;
`ifdef BIN2BCD_SIGNED_EN
  logic               neg_q, neg_d;
  logic               neg_pend_q, neg_pend_d;

  // Magnitude stays BIN_W bits wide so -2**(BIN_W-1) maps to 2**(BIN_W-1).
  assign mag = bus.bin[BIN_W-1] ? (~bus.bin + 1'b1) : bus.bin;
`else
  assign mag = bus.bin;
`endif

  always_comb begin
    corr = '0;
    for (int k = 0; k < DIGITS; k++) begin
      corr[4*k +: 4] = (dig_q[4*k +: 4] >= 4'd5) ? dig_q[4*k +: 4] + 4'd3 : dig_q[4*k +: 4];
    end
  end

  assign carry = corr[BCD_W-1];

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    neg_d      = neg_q;
    neg_pend_d = neg_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d   = mag;
          dig_d     = '0;
          cnt_d     = CNT_W'(BIN_W);
          ovf_acc_d = 1'b0;
          state_d   = SHIFT;
`ifdef BIN2BCD_SIGNED_EN
          neg_pend_d = bus.bin[BIN_W-1];
`endif
        end
      end
      SHIFT: begin
        dig_d     = {corr[BCD_W-2:0], shreg_q[BIN_W-1]};
        shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | carry;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = {corr[BCD_W-2:0], shreg_q[BIN_W-1]};
          ovf_d   = ovf_acc_q | carry;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef BIN2BCD_SIGNED_EN
          neg_d   = neg_pend_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      neg_q      <= 1'b0;
      neg_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef BIN2BCD_SIGNED_EN
      neg_q      <= neg_d;
      neg_pend_q <= neg_pend_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
  assign bus.neg  = neg_q;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: three instances (8b/3d, 4b/2d, 8b/2d) sharing clock and reset.
// Builds with or without BIN2BCD_SIGNED_EN.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic reset;
  int   sel;
  logic start_r;
  logic [7:0] bin_r;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bin2bcd_if #(.BIN_W(8), .DIGITS(3)) if8  ();
  bin2bcd_if #(.BIN_W(4), .DIGITS(2)) if4  ();
  bin2bcd_if #(.BIN_W(8), .DIGITS(2)) if82 ();

  assign if8.start  = start_r && (sel == 0);
  assign if4.start  = start_r && (sel == 1);
  assign if82.start = start_r && (sel == 2);
  assign if8.bin    = bin_r;
  assign if4.bin    = bin_r[3:0];
  assign if82.bin   = bin_r;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_b8  (.clk(clk), .reset(reset), .bus(if8));
  bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) u_b4  (.clk(clk), .reset(reset), .bus(if4));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b82 (.clk(clk), .reset(reset), .bus(if82));

  logic        done_m, busy_m, ovf_m;
  logic [11:0] bcd_m;
  always_comb begin
    done_m = if8.done; busy_m = if8.busy; ovf_m = if8.ovf; bcd_m = if8.bcd;
    if (sel == 1) begin
      done_m = if4.done; busy_m = if4.busy; ovf_m = if4.ovf; bcd_m = {4'h0, if4.bcd};
    end else if (sel == 2) begin
      done_m = if82.done; busy_m = if82.busy; ovf_m = if82.ovf; bcd_m = {4'h0, if82.bcd};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present start for one edge, then scramble bin to show it is ignored after acceptance.
  task automatic go(input int s, input logic [7:0] b);
    sel = s; start_r = 1'b1; bin_r = b;
    @(negedge clk);
    start_r = 1'b0; bin_r = 8'($urandom);
  endtask

  // n = edges from here until done is seen; busy_n = busy samples in the cycles before done, excluding the first.
  task automatic wait_done(output int n, output int busy_n);
    n = 0; busy_n = 0;
    while (!done_m && n < 40) begin
      if (n >= 1 && busy_m) busy_n++;
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_m), 32'd1);
  endtask

  int n, bn, dcount;
  logic [7:0] exp4;
  int m;

  initial begin
    reset = 1'b1; start_r = 1'b0; sel = 0; bin_r = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {29'd0, if8.busy, if4.busy, if82.busy}, 32'd0);
    check("rst_done", {29'd0, if8.done, if4.done, if82.done}, 32'd0);
    check("rst_bcd8", 32'(if8.bcd), 32'h000);
    check("rst_ovf",  {29'd0, if8.ovf, if4.ovf, if82.ovf}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // T1: full-scale operand, latency and busy window
    go(0, 8'd255);
    wait_done(n, bn);
    check("t1_latency", 32'(n), 32'd8);
    check("t1_busy7", 32'(bn), 32'd7);
    check("t1_busy_done", 32'(busy_m), 32'd0);
`ifdef BIN2BCD_SIGNED_EN
    check("t1_bcd255", 32'(bcd_m), 32'h001);
    check("t1_neg255", 32'(if8.neg), 32'd1);
`else
    check("t1_bcd255", 32'(bcd_m), 32'h255);
`endif
    check("t1_ovf255", 32'(ovf_m), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done_m), 32'd0);
    go(0, 8'd0);
    wait_done(n, bn);
    check("t1_bcd0", 32'(bcd_m), 32'h000);
    check("t1_ovf0", 32'(ovf_m), 32'd0);

    // T2: 4-bit / 2-digit exhaustive
    for (int v = 0; v < 16; v++) begin
`ifdef BIN2BCD_SIGNED_EN
      m = (v >= 8) ? 16 - v : v;
`else
      m = v;
`endif
      exp4 = 8'(((m / 10) << 4) | (m % 10));
      go(1, 8'(v));
      wait_done(n, bn);
      check($sformatf("t2_bcd_%0d", v), 32'(bcd_m), 32'(exp4));
      check($sformatf("t2_lat_%0d", v), 32'(n), 32'd4);
    end

    // T3: start during SHIFT ignored; back-to-back start in the done cycle
    go(0, 8'd99);
    repeat (2) @(negedge clk);
    start_r = 1'b1; bin_r = 8'd7;
    @(negedge clk);
    start_r = 1'b0; bin_r = 8'd0;
    wait_done(n, bn);
    check("t3_lat_ign", 32'(n), 32'd5);
    check("t3_bcd99", 32'(bcd_m), 32'h099);
    go(0, 8'd42);
    check("t3_done_pulse", 32'(done_m), 32'd0);
    wait_done(n, bn);
    check("t3_lat_b2b", 32'(n), 32'd8);
    check("t3_bcd42", 32'(bcd_m), 32'h042);

    // T4: reset mid-conversion aborts it
    go(0, 8'd255);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_busy", 32'(busy_m), 32'd0);
    check("t4_bcd", 32'(bcd_m), 32'h000);
    dcount = 0;
    repeat (12) begin
      if (done_m) dcount++;
      @(negedge clk);
    end
    check("t4_no_done", 32'(dcount), 32'd0);
    go(0, 8'd123);
    wait_done(n, bn);
    check("t4_bcd123", 32'(bcd_m), 32'h123);

    // reset has priority over start
    sel = 0; reset = 1'b1; start_r = 1'b1; bin_r = 8'd5;
    @(negedge clk);
    check("rst_over_start", 32'(busy_m), 32'd0);
    reset = 1'b0; start_r = 1'b0;
    @(negedge clk);
    check("rst_over_start2", 32'(busy_m), 32'd0);

    // T5: 8-bit / 2-digit overflow
    go(2, 8'd200);
    wait_done(n, bn);
`ifdef BIN2BCD_SIGNED_EN
    check("t5_ovf200", 32'(ovf_m), 32'd0);
    check("t5_bcd200", 32'(bcd_m), 32'h056);
`else
    check("t5_ovf200", 32'(ovf_m), 32'd1);
    check("t5_bcd200", 32'(bcd_m), 32'h000);
`endif
    go(2, 8'd99);
    wait_done(n, bn);
    check("t5_ovf99", 32'(ovf_m), 32'd0);
    check("t5_bcd99", 32'(bcd_m), 32'h099);
    go(2, 8'd127);
    wait_done(n, bn);
    check("t5_ovf127", 32'(ovf_m), 32'd1);
    check("t5_bcd127", 32'(bcd_m), 32'h027);

`ifdef BIN2BCD_SIGNED_EN
    // T6: signed operands
    go(0, 8'hF6);
    wait_done(n, bn);
    check("t6_negF6", 32'(if8.neg), 32'd1);
    check("t6_bcdF6", 32'(bcd_m), 32'h010);
    go(0, 8'h80);
    wait_done(n, bn);
    check("t6_neg80", 32'(if8.neg), 32'd1);
    check("t6_bcd80", 32'(bcd_m), 32'h128);
    go(0, 8'h7F);
    wait_done(n, bn);
    check("t6_neg7F", 32'(if8.neg), 32'd0);
    check("t6_bcd7F", 32'(bcd_m), 32'h127);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
